// File: rtl/dram_sram16_bridge.sv
// dram_sram16_bridge
// Serves 32-bit DRAM-port word requests by running two back-to-back 16-bit
// accesses on an asynchronous SRAM. The low halfword goes first, then the
// high halfword. The access is acknowledged with one dram_ack pulse.
//
// Optional build macro: SRAM_SKIP_UNUSED_HALF_EN
//   When defined, a write skips any halfword whose two byte enables are both 0.
//   When undefined, both halves always run. An unused half still strobes
//   we_n, but with lb_n = ub_n = 1.
//
// MEM_ADDR_BITS must be at least SRAM_ADDR_BITS-1. Request address bits above
// SRAM_ADDR_BITS-2 are ignored, so addresses wrap modulo the SRAM size.

`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 24
`endif

module dram_sram16_bridge #(
    parameter int MEM_ADDR_BITS  = `MEM_ADDR_BITS,
    parameter int SRAM_ADDR_BITS = 19,
    parameter int WAIT_CYCLES    = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      sync_reset,
    input  logic [MEM_ADDR_BITS-1:0]  dram_mem_addr,
    input  logic                      dram_mem_read_en,
    input  logic                      dram_mem_write_en,
    input  logic [3:0]                dram_mem_byte_enable,
    input  logic [31:0]               dram_mem_write_data,
    output logic                      dram_ack,
    output logic [31:0]               dram_mem_read_data,
    output logic [SRAM_ADDR_BITS-1:0] sram_addr,
    output logic [15:0]               sram_dq_out,
    output logic                      sram_dq_oe,
    input  logic [15:0]               sram_dq_in,
    output logic                      sram_ce_n,
    output logic                      sram_oe_n,
    output logic                      sram_we_n,
    output logic                      sram_lb_n,
    output logic                      sram_ub_n,
    output logic                      proto_err
);

    // Last value of the strobe counter before the strobe phase ends.
    localparam logic [3:0] LP_LAST = 4'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SETUP_LO  = 3'd1,
        S_STROBE_LO = 3'd2,
        S_SETUP_HI  = 3'd3,
        S_STROBE_HI = 3'd4,
        S_ACK       = 3'd5
    } state_t;

    // The register state always matches the phase the SRAM pins show. A
    // request is latched first (r_pend), and the first phase begins on the
    // following edge. That extra cycle is the "+1" in the ack latency.
    state_t                    r_state;
    logic [3:0]                r_cnt;
    logic                      r_pend;
    logic                      r_wr;
    logic [SRAM_ADDR_BITS-2:0] r_addr;
    logic [3:0]                r_be;
    logic [31:0]               r_wdata;
    logic [15:0]               r_rd_lo;

    state_t                    w_nxt;
    logic                      w_req;
    logic                      w_accept;
    logic                      w_busy_req;
    logic                      w_last;
    logic                      w_skip_lo;
    logic                      w_skip_hi;
    logic                      w_active;
    logic                      w_strobe;
    logic                      w_half_hi;
    logic [1:0]                w_half_be;
    logic [15:0]               w_half_dat;
    logic                      w_unused_addr;

    // Upper request-address bits are intentionally ignored.
    assign w_unused_addr = ^dram_mem_addr;

    assign w_req      = dram_mem_read_en | dram_mem_write_en;
    assign w_accept   = (r_state == S_IDLE) && !r_pend && w_req;
    assign w_busy_req = w_req && !w_accept;
    assign w_last     = (r_cnt == LP_LAST);

`ifdef SRAM_SKIP_UNUSED_HALF_EN
    assign w_skip_lo = r_wr && (r_be[1:0] == 2'b00);
    assign w_skip_hi = r_wr && (r_be[3:2] == 2'b00);
`else
    assign w_skip_lo = 1'b0;
    assign w_skip_hi = 1'b0;
`endif

    // Next phase of the two-halfword access sequence.
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_pend) begin
                    if (w_skip_lo) begin
                        w_nxt = w_skip_hi ? S_ACK : S_SETUP_HI;
                    end else begin
                        w_nxt = S_SETUP_LO;
                    end
                end
            end
            S_SETUP_LO:  w_nxt = S_STROBE_LO;
            S_STROBE_LO: begin
                if (w_last) begin
                    w_nxt = w_skip_hi ? S_ACK : S_SETUP_HI;
                end
            end
            S_SETUP_HI:  w_nxt = S_STROBE_HI;
            S_STROBE_HI: begin
                if (w_last) begin
                    w_nxt = S_ACK;
                end
            end
            S_ACK:       w_nxt = S_IDLE;
            default:     w_nxt = S_IDLE;
        endcase
    end

    // Decode the pin values for the phase about to begin, so each output is registered.
    always_comb begin
        w_active   = (w_nxt == S_SETUP_LO) || (w_nxt == S_STROBE_LO) ||
                     (w_nxt == S_SETUP_HI) || (w_nxt == S_STROBE_HI);
        w_strobe   = (w_nxt == S_STROBE_LO) || (w_nxt == S_STROBE_HI);
        w_half_hi  = (w_nxt == S_SETUP_HI) || (w_nxt == S_STROBE_HI);
        w_half_be  = w_half_hi ? r_be[3:2] : r_be[1:0];
        w_half_dat = w_half_hi ? r_wdata[31:16] : r_wdata[15:0];
    end

    // Request latch and low-half read capture; these are don't-care until qualified by r_pend / state.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr  <= dram_mem_addr[SRAM_ADDR_BITS-2:0];
            r_be    <= dram_mem_byte_enable;
            r_wdata <= dram_mem_write_data;
            r_wr    <= dram_mem_write_en;
        end
        if ((r_state == S_STROBE_LO) && w_last && !r_wr) begin
            r_rd_lo <= sram_dq_in;
        end
    end

    // Main sequencer: state, strobe counter, SRAM pins, ack, read word, error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state            <= S_IDLE;
            r_cnt              <= 4'd0;
            r_pend             <= 1'b0;
            sram_ce_n          <= 1'b1;
            sram_oe_n          <= 1'b1;
            sram_we_n          <= 1'b1;
            sram_lb_n          <= 1'b1;
            sram_ub_n          <= 1'b1;
            sram_dq_oe         <= 1'b0;
            sram_addr          <= '0;
            sram_dq_out        <= 16'd0;
            dram_ack           <= 1'b0;
            dram_mem_read_data <= 32'd0;
            proto_err          <= 1'b0;
        end else if (sync_reset) begin
            r_state            <= S_IDLE;
            r_cnt              <= 4'd0;
            r_pend             <= 1'b0;
            sram_ce_n          <= 1'b1;
            sram_oe_n          <= 1'b1;
            sram_we_n          <= 1'b1;
            sram_lb_n          <= 1'b1;
            sram_ub_n          <= 1'b1;
            sram_dq_oe         <= 1'b0;
            sram_addr          <= '0;
            sram_dq_out        <= 16'd0;
            dram_ack           <= 1'b0;
            dram_mem_read_data <= 32'd0;
            proto_err          <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_pend  <= w_accept;

            // A request while busy is dropped. Simultaneous read+write runs as a write.
            if (w_busy_req || (w_accept && dram_mem_read_en && dram_mem_write_en)) begin
                proto_err <= 1'b1;
            end

            // The counter restarts on strobe entry and advances while the strobe continues.
            if (w_strobe && (r_state == w_nxt)) begin
                r_cnt <= r_cnt + 4'd1;
            end else begin
                r_cnt <= 4'd0;
            end

            sram_ce_n  <= !w_active;
            sram_oe_n  <= !(w_strobe && !r_wr);
            sram_we_n  <= !(w_strobe && r_wr);
            sram_dq_oe <= w_active && r_wr;
            if (w_active) begin
                sram_addr <= {r_addr, w_half_hi};
                if (r_wr) begin
                    sram_dq_out <= w_half_dat;
                end
            end
            if (!w_active) begin
                {sram_ub_n, sram_lb_n} <= 2'b11;
            end else if (r_wr) begin
                {sram_ub_n, sram_lb_n} <= ~w_half_be;
            end else begin
                {sram_ub_n, sram_lb_n} <= 2'b00;
            end

            dram_ack <= (w_nxt == S_ACK);

            // The high half is captured on the edge that raises the read ack.
            if ((r_state == S_STROBE_HI) && w_last && !r_wr) begin
                dram_mem_read_data <= {sram_dq_in, r_rd_lo};
            end
        end
    end

endmodule

// File: tb/tb_dram_sram16_bridge.sv
// Directed testbench for dram_sram16_bridge with a behavioural 16-bit SRAM.
module tb_dram_sram16_bridge;

    logic        clk;
    logic        reset_n;
    logic        sync_reset;
    logic [23:0] dram_mem_addr;
    logic        dram_mem_read_en;
    logic        dram_mem_write_en;
    logic [3:0]  dram_mem_byte_enable;
    logic [31:0] dram_mem_write_data;
    logic        dram_ack;
    logic [31:0] dram_mem_read_data;
    logic [18:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;
    logic        proto_err;

    int total;
    int bad;

    logic [15:0] mem [0:255];
    logic        pl_en;
    logic [7:0]  pl_a;
    logic [15:0] pl_d;

    int          s_lat, s_acks, s_oe_lo, s_oe_hi, s_we_lo, s_we_hi, s_dqoe_bad;
    logic [1:0]  s_lo_lanes, s_hi_lanes;
    logic [15:0] s_hi_dq;
    logic [18:0] s_lo_addr, s_hi_addr;

    dram_sram16_bridge #(
        .MEM_ADDR_BITS(24),
        .SRAM_ADDR_BITS(19),
        .WAIT_CYCLES(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sync_reset(sync_reset),
        .dram_mem_addr(dram_mem_addr),
        .dram_mem_read_en(dram_mem_read_en),
        .dram_mem_write_en(dram_mem_write_en),
        .dram_mem_byte_enable(dram_mem_byte_enable),
        .dram_mem_write_data(dram_mem_write_data),
        .dram_ack(dram_ack),
        .dram_mem_read_data(dram_mem_read_data),
        .sram_addr(sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in),
        .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n),
        .sram_lb_n(sram_lb_n),
        .sram_ub_n(sram_ub_n),
        .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: asynchronous read, byte-lane write while ce_n and we_n are low.
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 16'h0000;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_a] <= pl_d;
        end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            if (!sram_lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dq_out[7:0];
            if (!sram_ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq_out[15:8];
        end
    end

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        pl_en = 1'b1;
        pl_a  = a;
        pl_d  = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issues one request and watches 12 cycles after the request edge.
    // When inj > 0, an extra read pulse is sampled on edge inj+1.
    task automatic do_req(input logic rd, input logic wr, input logic [23:0] addr,
                          input logic [3:0] be, input logic [31:0] data, input int inj);
        s_lat = -1; s_acks = 0; s_oe_lo = 0; s_oe_hi = 0; s_we_lo = 0; s_we_hi = 0;
        s_dqoe_bad = 0; s_lo_lanes = 2'bxx; s_hi_lanes = 2'bxx; s_hi_dq = 16'hxxxx;
        s_lo_addr = 'x; s_hi_addr = 'x;
        @(negedge clk);
        dram_mem_read_en     = rd;
        dram_mem_write_en    = wr;
        dram_mem_addr        = addr;
        dram_mem_byte_enable = be;
        dram_mem_write_data  = data;
        @(negedge clk);
        dram_mem_read_en  = 1'b0;
        dram_mem_write_en = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (dram_ack) begin
                s_acks++;
                if (s_lat < 0) s_lat = c;
            end
            if (!sram_ce_n) begin
                if (sram_addr[0]) s_hi_addr = sram_addr; else s_lo_addr = sram_addr;
            end
            if (!sram_ce_n && !sram_oe_n) begin
                if (sram_addr[0]) s_oe_hi++; else s_oe_lo++;
            end
            if (!sram_ce_n && !sram_we_n) begin
                if (!sram_dq_oe) s_dqoe_bad++;
                if (sram_addr[0]) begin
                    s_we_hi++;
                    s_hi_lanes = {sram_ub_n, sram_lb_n};
                    s_hi_dq    = sram_dq_out;
                end else begin
                    s_we_lo++;
                    s_lo_lanes = {sram_ub_n, sram_lb_n};
                end
            end
            if (inj > 0 && c == inj) begin
                dram_mem_addr    = 24'h000003;
                dram_mem_read_en = 1'b1;
            end else if (inj > 0 && c == inj + 1) begin
                dram_mem_read_en = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n} !== 5'b11111) begin
            bad++; $display("FAIL reset_ctrl got=%b want=11111",
                            {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n});
        end
        total++;
        if ({sram_dq_oe, dram_ack, proto_err} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got=%b want=000", {sram_dq_oe, dram_ack, proto_err});
        end
        total++;
        if (sram_addr !== 19'h0 || sram_dq_out !== 16'h0 || dram_mem_read_data !== 32'h0) begin
            bad++; $display("FAIL reset_data addr=%h dq=%h rd=%h want zeros",
                            sram_addr, sram_dq_out, dram_mem_read_data);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_read();
        preload(8'h20, 16'hBEEF);
        preload(8'h21, 16'hDEAD);
        do_req(1'b1, 1'b0, 24'h000010, 4'hF, 32'h0, 0);
        total++;
        if (s_lat !== 7) begin bad++; $display("FAIL read_latency got=%0d want=7", s_lat); end
        total++;
        if (dram_mem_read_data !== 32'hDEADBEEF) begin
            bad++; $display("FAIL read_data got=%h want=deadbeef", dram_mem_read_data);
        end
        total++;
        if (s_oe_lo !== 2 || s_oe_hi !== 2) begin
            bad++; $display("FAIL read_oe_cycles got=%0d/%0d want=2/2", s_oe_lo, s_oe_hi);
        end
        total++;
        if (s_lo_addr !== 19'h20 || s_hi_addr !== 19'h21) begin
            bad++; $display("FAIL read_addr got=%h/%h want=20/21", s_lo_addr, s_hi_addr);
        end
        total++;
        if (s_acks !== 1 || (s_we_lo + s_we_hi) !== 0 || proto_err !== 1'b0) begin
            bad++; $display("FAIL read_misc acks=%0d we=%0d perr=%b want 1/0/0",
                            s_acks, s_we_lo + s_we_hi, proto_err);
        end
    endtask

    task automatic test_write_full();
        do_req(1'b0, 1'b1, 24'h000003, 4'b1111, 32'h12345678, 0);
        total++;
        if (mem[6] !== 16'h5678 || mem[7] !== 16'h1234) begin
            bad++; $display("FAIL wfull_mem got=%h/%h want=5678/1234", mem[6], mem[7]);
        end
        total++;
        if (s_lat !== 7) begin bad++; $display("FAIL wfull_latency got=%0d want=7", s_lat); end
        total++;
        if (s_we_lo !== 2 || s_we_hi !== 2 || s_dqoe_bad !== 0) begin
            bad++; $display("FAIL wfull_we got=%0d/%0d dqoe_bad=%0d want=2/2/0",
                            s_we_lo, s_we_hi, s_dqoe_bad);
        end
        total++;
        if (s_lo_lanes !== 2'b00 || s_hi_lanes !== 2'b00) begin
            bad++; $display("FAIL wfull_lanes got=%b/%b want=00/00", s_lo_lanes, s_hi_lanes);
        end
        total++;
        if (dram_mem_read_data !== 32'hDEADBEEF || (s_oe_lo + s_oe_hi) !== 0) begin
            bad++; $display("FAIL wfull_rdhold got=%h oe=%0d want=deadbeef/0",
                            dram_mem_read_data, s_oe_lo + s_oe_hi);
        end
    endtask

    task automatic test_write_partial();
        preload(8'h10, 16'h1111);
        preload(8'h11, 16'h2222);
        do_req(1'b0, 1'b1, 24'h000008, 4'b0100, 32'hAABBCCDD, 0);
        total++;
        if (s_hi_lanes !== 2'b10 || s_hi_dq !== 16'hAABB) begin
            bad++; $display("FAIL wpart_hi got=%b/%h want=10/aabb", s_hi_lanes, s_hi_dq);
        end
        total++;
        if (mem[8'h10] !== 16'h1111 || mem[8'h11] !== 16'h22BB) begin
            bad++; $display("FAIL wpart_mem got=%h/%h want=1111/22bb", mem[8'h10], mem[8'h11]);
        end
`ifdef SRAM_SKIP_UNUSED_HALF_EN
        total++;
        if (s_lat !== 4 || s_we_lo !== 0) begin
            bad++; $display("FAIL wpart_skip lat=%0d we_lo=%0d want=4/0", s_lat, s_we_lo);
        end
`else
        total++;
        if (s_lat !== 7 || s_we_lo !== 2 || s_lo_lanes !== 2'b11) begin
            bad++; $display("FAIL wpart_noskip lat=%0d we_lo=%0d lanes=%b want=7/2/11",
                            s_lat, s_we_lo, s_lo_lanes);
        end
`endif
    endtask

    task automatic test_be_zero();
        preload(8'h30, 16'h3333);
        preload(8'h31, 16'h4444);
        do_req(1'b0, 1'b1, 24'h000018, 4'b0000, 32'hFFFFFFFF, 0);
        total++;
        if (mem[8'h30] !== 16'h3333 || mem[8'h31] !== 16'h4444 || s_acks !== 1) begin
            bad++; $display("FAIL bezero_mem got=%h/%h acks=%0d want=3333/4444/1",
                            mem[8'h30], mem[8'h31], s_acks);
        end
`ifdef SRAM_SKIP_UNUSED_HALF_EN
        total++;
        if (s_lat !== 1 || (s_we_lo + s_we_hi) !== 0) begin
            bad++; $display("FAIL bezero_skip lat=%0d we=%0d want=1/0", s_lat, s_we_lo + s_we_hi);
        end
`else
        total++;
        if (s_lat !== 7 || s_we_lo !== 2 || s_we_hi !== 2) begin
            bad++; $display("FAIL bezero_noskip lat=%0d we=%0d/%0d want=7/2/2",
                            s_lat, s_we_lo, s_we_hi);
        end
`endif
    endtask

    task automatic test_overlap();
        do_req(1'b1, 1'b0, 24'h000010, 4'hF, 32'h0, 2);
        total++;
        if (s_acks !== 1 || s_lat !== 7) begin
            bad++; $display("FAIL overlap_ack acks=%0d lat=%0d want=1/7", s_acks, s_lat);
        end
        total++;
        if (dram_mem_read_data !== 32'hDEADBEEF) begin
            bad++; $display("FAIL overlap_data got=%h want=deadbeef", dram_mem_read_data);
        end
        total++;
        if (proto_err !== 1'b1 || s_oe_lo !== 2 || s_oe_hi !== 2) begin
            bad++; $display("FAIL overlap_err perr=%b oe=%0d/%0d want=1/2/2",
                            proto_err, s_oe_lo, s_oe_hi);
        end
    endtask

    task automatic test_sync_reset();
        @(negedge clk);
        sync_reset = 1'b1;
        @(negedge clk);
        sync_reset = 1'b0;
        total++;
        if (proto_err !== 1'b0 || dram_mem_read_data !== 32'h0 || sram_ce_n !== 1'b1) begin
            bad++; $display("FAIL sync_reset perr=%b rd=%h ce_n=%b want=0/0/1",
                            proto_err, dram_mem_read_data, sram_ce_n);
        end
    endtask

    task automatic test_both();
        preload(8'h40, 16'h0000);
        preload(8'h41, 16'h0000);
        do_req(1'b1, 1'b1, 24'h000020, 4'b1111, 32'hCAFEF00D, 0);
        total++;
        if (mem[8'h40] !== 16'hF00D || mem[8'h41] !== 16'hCAFE) begin
            bad++; $display("FAIL both_mem got=%h/%h want=f00d/cafe", mem[8'h40], mem[8'h41]);
        end
        total++;
        if (proto_err !== 1'b1 || (s_oe_lo + s_oe_hi) !== 0 || s_lat !== 7) begin
            bad++; $display("FAIL both_err perr=%b oe=%0d lat=%0d want=1/0/7",
                            proto_err, s_oe_lo + s_oe_hi, s_lat);
        end
    endtask

    task automatic test_reset_mid();
        int acks;
        @(negedge clk);
        dram_mem_addr    = 24'h000010;
        dram_mem_read_en = 1'b1;
        @(negedge clk);
        dram_mem_read_en = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (sram_oe_n !== 1'b0 || sram_addr !== 19'h21) begin
            bad++; $display("FAIL rmid_pre oe_n=%b addr=%h want=0/21", sram_oe_n, sram_addr);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_dq_oe} !== 6'b111110) begin
            bad++; $display("FAIL rmid_ctrl got=%b want=111110",
                            {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_dq_oe});
        end
        @(negedge clk);
        reset_n = 1'b1;
        acks = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (dram_ack) acks++;
        end
        total++;
        if (acks !== 0 || dram_mem_read_data !== 32'h0) begin
            bad++; $display("FAIL rmid_noack acks=%0d rd=%h want=0/0", acks, dram_mem_read_data);
        end
        do_req(1'b1, 1'b0, 24'h000010, 4'hF, 32'h0, 0);
        total++;
        if (dram_mem_read_data !== 32'hDEADBEEF || s_lat !== 7 || s_acks !== 1) begin
            bad++; $display("FAIL rmid_after rd=%h lat=%0d acks=%0d want=deadbeef/7/1",
                            dram_mem_read_data, s_lat, s_acks);
        end
    endtask

    task automatic test_wrap();
        preload(8'h20, 16'h1357);
        preload(8'h21, 16'h2468);
        do_req(1'b1, 1'b0, 24'hFC0010, 4'hF, 32'h0, 0);
        total++;
        if (s_lo_addr !== 19'h20 || s_hi_addr !== 19'h21) begin
            bad++; $display("FAIL wrap_addr got=%h/%h want=20/21", s_lo_addr, s_hi_addr);
        end
        total++;
        if (dram_mem_read_data !== 32'h24681357) begin
            bad++; $display("FAIL wrap_data got=%h want=24681357", dram_mem_read_data);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_n              = 1'b0;
        sync_reset           = 1'b0;
        dram_mem_addr        = 24'h0;
        dram_mem_read_en     = 1'b0;
        dram_mem_write_en    = 1'b0;
        dram_mem_byte_enable = 4'h0;
        dram_mem_write_data  = 32'h0;
        pl_en = 1'b0;
        pl_a  = 8'h0;
        pl_d  = 16'h0;

        test_reset();
        test_read();
        test_write_full();
        test_write_partial();
        test_be_zero();
        test_overlap();
        test_sync_reset();
        test_both();
        test_reset_mid();
        test_wrap();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dram_sram16_bridge.md
Name: dram_sram16_bridge

Overview:
- Sits directly downstream of the MCU's external DRAM port and serves its dram_* word requests.
- Turns each 32-bit read or write into two sequential 16-bit accesses on an asynchronous SRAM. Low halfword goes first, high halfword second.
- Timing is programmable through a wait-state count.
- Returns dram_ack with read data assembled into one 32-bit word.

Parameters:
- MEM_ADDR_BITS, default `MEM_ADDR_BITS: word address width of the request port.
- SRAM_ADDR_BITS, default 19: halfword address width of the SRAM.
- WAIT_CYCLES, default 2, legal range 1..15: strobe-low cycles per halfword access.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sync_reset  in  1  synchronous reset; same effect as reset_n, applied on the clock edge
- dram_mem_addr  in  MEM_ADDR_BITS  word address
- dram_mem_read_en  in  1  one-cycle read request pulse
- dram_mem_write_en  in  1  one-cycle write request pulse
- dram_mem_byte_enable  in  4  byte lanes for writes; bit0 = bits 7:0
- dram_mem_write_data  in  32  write word
- dram_ack  out  1  one-cycle completion pulse, for reads and writes
- dram_mem_read_data  out  32  read word; valid with dram_ack, held until the next ack
- sram_addr  out  SRAM_ADDR_BITS  halfword address = {dram_mem_addr[SRAM_ADDR_BITS-2:0], half}
- sram_dq_out  out  16  write data
- sram_dq_oe  out  1  data bus drive enable
- sram_dq_in  in  16  read data
- sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n  out  1 each  active-low SRAM controls
- proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset values (reset_n low, or sync_reset high at an edge):
  - state IDLE;
  - sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n = 1;
  - sram_dq_oe = 0; sram_addr = 0; sram_dq_out = 0;
  - dram_ack = 0; dram_mem_read_data = 0; proto_err = 0.
- A reset in the middle of a transaction aborts it. No ack is issued and the SRAM controls return high in the next cycle.
- All outputs are registered.
- Request capture in IDLE:
  - address, byte enables, write data and direction are latched on the edge where read_en or write_en is 1.
  - If read_en and write_en are both 1: treat the request as a write and set proto_err.
- States: IDLE -> SETUP_LO -> STROBE_LO -> SETUP_HI -> STROBE_HI -> ACK -> IDLE.
- SETUP_x (1 cycle):
  - sram_ce_n = 0; sram_addr holds the half address (half = 0 in LO, 1 in HI).
  - oe_n and we_n stay 1.
  - For writes: dq_oe = 1 and dq_out = the selected halfword.
  - lb_n/ub_n = inverted byte enables for writes (bits 1:0 in LO, 3:2 in HI); 0/0 for reads.
- STROBE_x (WAIT_CYCLES cycles, counted by a 4-bit counter):
  - oe_n = 0 for reads, we_n = 0 for writes; address, data and lanes stay stable.
  - Reads capture sram_dq_in on the edge that ends the last strobe cycle, into bits 15:0 (LO) or 31:16 (HI).
  - we_n and oe_n return to 1 in the next SETUP or ACK cycle, together with ce_n.
- ACK (1 cycle):
  - dram_ack = 1; ce_n = 1; dq_oe = 0.
  - dram_mem_read_data is updated only on read acks; write acks leave it unchanged.
- Latency: dram_ack rises 2*(1+WAIT_CYCLES)+1 cycles after the request edge (7 cycles at the default).
- A request pulse outside IDLE is dropped, sets proto_err, and does not disturb the transaction in flight.
- proto_err clears only on reset.
- Address bits above SRAM_ADDR_BITS-2 are ignored, so addresses wrap modulo the SRAM size.

Optional Feature:
- Macro: SRAM_SKIP_UNUSED_HALF_EN.
- When defined, for writes only:
  - a halfword whose two byte enables are both 0 is skipped, going straight to the next phase (SETUP_HI or ACK);
  - a write with byte_enable = 4'b0000 acks on the cycle after the request edge (latency 1);
  - a write with only the HI lanes enabled has latency 1+WAIT_CYCLES+1.
- When not defined:
  - both halves are always run;
  - an unused half still pulses we_n low, with lb_n = ub_n = 1.

Test Plan:
- Read at addr 0x00010, SRAM half 0x20 = 0xBEEF, half 0x21 = 0xDEAD, WAIT_CYCLES = 2 -> dram_ack 7 cycles after the request; read_data = 0xDEADBEEF; oe_n low for exactly 2 cycles per half.
- Write 0x12345678 with byte_enable 4'b1111 to addr 0x3 -> halves 0x6 = 0x5678 and 0x7 = 0x1234; lb_n = ub_n = 0; we_n low 2 cycles per half; ack at cycle 7.
- Write with byte_enable 4'b0100, data 0xAABBCCDD -> HI half ub_n = 1, lb_n = 0, dq_out = 0xAABB. Without the macro: LO half has lb_n = ub_n = 1 and ack at cycle 7. With SRAM_SKIP_UNUSED_HALF_EN: LO half is skipped and ack comes at cycle 4.
- read_en pulsed again 3 cycles into a read -> the second request is ignored, proto_err = 1, the first read completes with correct data, only one ack.
- reset_n asserted in STROBE_HI of a read -> all control outputs go high and dq_oe = 0 immediately; no ack; a subsequent read completes normally.
- read_en and write_en both high together -> write performed, proto_err = 1.
